pipe_ifid_ctrl: RTL and testbench
=================================

Name: pipe_ifid_ctrl

Overview:
- IF/ID pipeline register plus ID-stage hazard and flush control for the 5-stage MIPS pipeline.
- Sits directly downstream of the IF stage:
  - latches the fetched instruction and PC+4;
  - detects load-use hazards;
  - flushes on taken branches, jumps and interrupts;
  - drives PCWrite/Stall back to the IF stage.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word inserted on a bubble or flush.
- IRQ_SYNC, 2, number of synchroniser flops on IRQ (min 2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- IF_Instruct  input  32  instruction from IF stage.
- IF_PC4  input  32  PC+4 from IF; bit 31 is the supervisor flag.
- ID_EX_MemRead  input  1  instruction in EX is a load.
- ID_EX_Rt  input  5  load destination register in EX.
- EX_BranchTaken  input  1  branch resolved taken in EX this cycle.
- ID_Jump  input  1  ID-stage decode says j/jal/jr/jalr.
- IRQ  input  1  external interrupt, asynchronous, level.
- ID_Instruct  output  32  registered instruction for ID.
- ID_PC4  output  32  registered PC+4 for ID.
- ID_Valid  output  1  ID slot holds a real instruction.
- PCWrite  output  1  IF may update PC.
- Stall  output  1  IF/ID hold; also tells IF to keep its output.
- ID_EX_Bubble  output  1  downstream must load a bubble into ID/EX.
- IRQ_Taken  output  1  one-cycle pulse: interrupt accepted; IF selects the vector.
- EPC  output  32  PC+4 of the flushed instruction, saved on IRQ_Taken.

Behaviour:
- Reset (reset=0, async):
  - ID_Instruct=NOP_WORD, ID_PC4=0, ID_Valid=0, EPC=0.
  - IRQ synchroniser and pending flag cleared.
  - Combinational outputs evaluate from the cleared state: PCWrite=1, Stall=0, ID_EX_Bubble=0, IRQ_Taken=0.
- Load-use hazard (combinational):
  - Asserted when ID_Valid and ID_EX_MemRead and ID_EX_Rt!=0 and ID_EX_Rt equals ID_Instruct[25:21] or ID_Instruct[20:16].
  - Both fields are compared regardless of opcode (conservative).
- IRQ path:
  - IRQ passes through IRQ_SYNC flops.
  - Synchronised level sets a sticky pending flag when ID_PC4[31]==0 (user mode).
  - Supervisor-mode IRQ is ignored until mode returns to user.
- Per-cycle priority (highest first):
  1. EX_BranchTaken: next IF/ID=NOP, ID_Valid=0; PCWrite=1, Stall=0; ID_EX_Bubble=1. Overrides load-use and IRQ; IRQ stays pending.
  2. IRQ accept (pending, ID_Valid, no load-use): IRQ_Taken=1; EPC<=ID_PC4; pending cleared; next IF/ID=NOP; ID_EX_Bubble=1; PCWrite=1.
  3. Load-use: PCWrite=0, Stall=1; IF/ID holds current contents; ID_EX_Bubble=1. Lasts exactly one cycle per hazard, since the load moves to MEM next cycle.
  4. ID_Jump (ID_Valid): next IF/ID=NOP (kills the delay-slot fetch); ID_EX_Bubble=0, because the jump itself proceeds; PCWrite=1.
  5. Normal: IF/ID <= {IF_Instruct, IF_PC4}, ID_Valid<=1, PCWrite=1, Stall=0.
- Simultaneous events:
  - Jump + load-use: stall wins; the jump re-evaluates next cycle.
  - Branch + jump: branch wins; the jump in ID is on the wrong path.
- Latency: one cycle from IF inputs to ID outputs.
- Stall, PCWrite, ID_EX_Bubble and IRQ_Taken are combinational from registered state and current-cycle inputs; no internal combinational loop.
- IRQ_Taken never asserts on two consecutive cycles.
- Reset mid-stall: everything clears immediately; the first post-reset cycle is Normal.

Decomposition:
- Shared package pipe_pkg:
  - NOP_WORD and the instruction field ranges (RS 25:21, RT 20:16);
  - the supervisor bit index (31).
- One natural sub-module: pipe_irq_sync, covering the synchroniser, pending flag and mode gating.
- Hazard compare and register logic stay in the top.

Test Plan:
- Reset while ID holds 32'h8C22_0004 -> outputs NOP/0/0 asynchronously; next edge with reset=1 loads IF_Instruct=32'h2001_0005, IF_PC4=32'h0000_0008, ID_Valid=1.
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=2, ID holds 32'h0041_1820 (add $3,$2,$1) -> Stall=1, PCWrite=0, ID_EX_Bubble=1 for exactly one cycle; ID_Instruct held; ID_EX_Rt=0 variant -> no stall.
- EX_BranchTaken=1 during a load-use stall -> Stall=0, PCWrite=1, next ID_Instruct=NOP, ID_Valid=0.
- ID_Jump=1 with ID_Instruct=32'h0800_0010 -> next ID_Instruct=NOP, ID_EX_Bubble=0, PCWrite=1.
- IRQ rises with ID_PC4=32'h0000_0040 -> IRQ_Taken pulses one cycle IRQ_SYNC+1 cycles later; EPC=32'h0000_0040 (ID_PC4 in the accept cycle); ID flushed.
- IRQ with ID_PC4=32'h8000_0040 -> no IRQ_Taken until ID_PC4[31]=0.
- IRQ pending coincident with EX_BranchTaken -> accepted on the first subsequent cycle with ID_Valid=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, instruction field helpers and the per-cycle action type
// for the IF/ID pipeline register and its hazard/flush control.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int SUPV_BIT = 31;

  typedef enum logic [2:0] {
    ACT_NORMAL   = 3'd0,
    ACT_BRANCH   = 3'd1,
    ACT_IRQ      = 3'd2,
    ACT_LOAD_USE = 3'd3,
    ACT_JUMP     = 3'd4
  } id_action_e;

  function automatic logic [4:0] rs_field(input logic [31:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] rt_field(input logic [31:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/pipe_ifid_ctrl_if.sv
// Signal bundle between the IF/ID control block and its surrounding pipeline.
// slave is the control block itself; master is the surrounding pipeline.
interface pipe_ifid_ctrl_if;

  logic [31:0] IF_Instruct;
  logic [31:0] IF_PC4;
  logic        ID_EX_MemRead;
  logic [4:0]  ID_EX_Rt;
  logic        EX_BranchTaken;
  logic        ID_Jump;
  logic        IRQ;
  logic [31:0] ID_Instruct;
  logic [31:0] ID_PC4;
  logic        ID_Valid;
  logic        PCWrite;
  logic        Stall;
  logic        ID_EX_Bubble;
  logic        IRQ_Taken;
  logic [31:0] EPC;

  modport master (
    output IF_Instruct, IF_PC4, ID_EX_MemRead, ID_EX_Rt, EX_BranchTaken, ID_Jump, IRQ,
    input  ID_Instruct, ID_PC4, ID_Valid, PCWrite, Stall, ID_EX_Bubble, IRQ_Taken, EPC
  );

  modport slave (
    input  IF_Instruct, IF_PC4, ID_EX_MemRead, ID_EX_Rt, EX_BranchTaken, ID_Jump, IRQ,
    output ID_Instruct, ID_PC4, ID_Valid, PCWrite, Stall, ID_EX_Bubble, IRQ_Taken, EPC
  );

endinterface

// File: rtl/pipe_irq_sync.sv
// External interrupt synchroniser and sticky pending flag; a request only
// becomes pending while the instruction in ID runs in user mode.
module pipe_irq_sync #(
  parameter int IRQ_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic user_mode,
  input  logic accept,
  output logic pending
);

  logic [IRQ_SYNC-1:0] sync_r;
  logic                pending_r;
  logic                pending_s;

  // Synchroniser chain on the asynchronous interrupt level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {IRQ_SYNC{1'b0}};
    end else begin
      sync_r <= {sync_r[IRQ_SYNC-2:0], irq};
    end
  end

  // Acceptance clears the flag even if the level is still present
  always_comb begin
    pending_s = pending_r;
    if (accept) begin
      pending_s = 1'b0;
    end else if (sync_r[IRQ_SYNC-1] && user_mode) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // Pending flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_s;
    end
  end

  assign pending = pending_r;

endmodule

// File: rtl/pipe_ifid_ctrl.sv
// IF/ID pipeline register with load-use stall, branch/jump/interrupt flush
// and PC write control for the 5-stage MIPS pipeline.
module pipe_ifid_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_INSTR,
  parameter int          IRQ_SYNC = 2
) (
  input logic              clk,
  input logic              reset,
  pipe_ifid_ctrl_if.slave  bus
);

  logic [31:0] id_instr_r;
  logic [31:0] id_pc4_r;
  logic        id_valid_r;
  logic [31:0] epc_r;
  logic        irq_pending_s;
  logic        load_use_s;
  logic        irq_accept_s;
  logic        pc_write_s;
  logic        stall_s;
  logic        bubble_s;
  id_action_e  action_s;

  pipe_irq_sync #(.IRQ_SYNC(IRQ_SYNC)) u_irq_sync (
    .clk       (clk),
    .rst_n     (reset),
    .irq       (bus.IRQ),
    .user_mode (~id_pc4_r[SUPV_BIT]),
    .accept    (irq_accept_s),
    .pending   (irq_pending_s)
  );

  // Load-use compare (both fields, opcode-agnostic) and priority resolution
  always_comb begin
    load_use_s = 1'b0;
    action_s   = ACT_NORMAL;
    if (id_valid_r && bus.ID_EX_MemRead && (bus.ID_EX_Rt != 5'd0) &&
        ((bus.ID_EX_Rt == rs_field(id_instr_r)) || (bus.ID_EX_Rt == rt_field(id_instr_r)))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
    if (bus.EX_BranchTaken) begin
      action_s = ACT_BRANCH;
    end else if (irq_pending_s && id_valid_r && !load_use_s) begin
      action_s = ACT_IRQ;
    end else if (load_use_s) begin
      action_s = ACT_LOAD_USE;
    end else if (id_valid_r && bus.ID_Jump) begin
      action_s = ACT_JUMP;
    end else begin
      action_s = ACT_NORMAL;
    end
  end

  // Control outputs decoded from the winning action
  always_comb begin
    pc_write_s   = 1'b1;
    stall_s      = 1'b0;
    bubble_s     = 1'b0;
    irq_accept_s = 1'b0;
    case (action_s)
      ACT_BRANCH:   bubble_s = 1'b1;
      ACT_IRQ: begin
        bubble_s     = 1'b1;
        irq_accept_s = 1'b1;
      end
      ACT_LOAD_USE: begin
        pc_write_s = 1'b0;
        stall_s    = 1'b1;
        bubble_s   = 1'b1;
      end
      ACT_JUMP:     bubble_s = 1'b0;
      ACT_NORMAL:   bubble_s = 1'b0;
      default:      bubble_s = 1'b0;
    endcase
  end

  // IF/ID register; flushes keep the fetched PC+4 so the mode bit tracks fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_instr_r <= NOP_WORD;
      id_pc4_r   <= 32'h0000_0000;
      id_valid_r <= 1'b0;
    end else begin
      case (action_s)
        ACT_LOAD_USE: begin
          id_instr_r <= id_instr_r;
          id_pc4_r   <= id_pc4_r;
          id_valid_r <= id_valid_r;
        end
        ACT_BRANCH, ACT_IRQ, ACT_JUMP: begin
          id_instr_r <= NOP_WORD;
          id_pc4_r   <= bus.IF_PC4;
          id_valid_r <= 1'b0;
        end
        default: begin
          id_instr_r <= bus.IF_Instruct;
          id_pc4_r   <= bus.IF_PC4;
          id_valid_r <= 1'b1;
        end
      endcase
    end
  end

  // Exception PC capture on interrupt acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_r <= 32'h0000_0000;
    end else if (irq_accept_s) begin
      epc_r <= id_pc4_r;
    end else begin
      epc_r <= epc_r;
    end
  end

  assign bus.ID_Instruct  = id_instr_r;
  assign bus.ID_PC4       = id_pc4_r;
  assign bus.ID_Valid     = id_valid_r;
  assign bus.EPC          = epc_r;
  assign bus.PCWrite      = pc_write_s;
  assign bus.Stall        = stall_s;
  assign bus.ID_EX_Bubble = bubble_s;
  assign bus.IRQ_Taken    = irq_accept_s;

endmodule

// File: tb/tb_pipe_ifid_ctrl.sv
// Directed plus randomized bench for pipe_ifid_ctrl against a cycle-level
// reference model of the IF/ID priority rules and IRQ synchroniser delay.
module tb_pipe_ifid_ctrl;

  localparam int          IRQ_SYNC = 2;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  pipe_ifid_ctrl_if bus ();

  pipe_ifid_ctrl #(.NOP_WORD(NOP), .IRQ_SYNC(IRQ_SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // reference model state
  logic [31:0] m_instr, m_pc4, m_epc;
  logic        m_valid, m_pend;
  logic        irq_q[$];
  logic        e_pcw, e_stall, e_bub, e_take;
  int          m_kind; // 0 load, 1 flush, 2 hold

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = NOP; m_pc4 = 32'h0; m_epc = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
    irq_q.delete();
    for (int i = 0; i < IRQ_SYNC; i++) irq_q.push_back(1'b0);
  endtask

  task automatic model_eval();
    logic [4:0]  r;
    logic [31:0] w;
    logic        lu;
    r  = bus.ID_EX_Rt;
    w  = m_instr;
    lu = m_valid && bus.ID_EX_MemRead && (r != 5'd0) && ((r == w[25:21]) || (r == w[20:16]));
    e_pcw = 1'b1; e_stall = 1'b0; e_bub = 1'b0; e_take = 1'b0;
    if (bus.EX_BranchTaken) begin
      e_bub = 1'b1; m_kind = 1;
    end else if (m_pend && m_valid && !lu) begin
      e_take = 1'b1; e_bub = 1'b1; m_kind = 1;
    end else if (lu) begin
      e_pcw = 1'b0; e_stall = 1'b1; e_bub = 1'b1; m_kind = 2;
    end else if (m_valid && bus.ID_Jump) begin
      m_kind = 1;
    end else begin
      m_kind = 0;
    end
  endtask

  task automatic model_commit();
    logic s;
    s = irq_q.pop_front();
    irq_q.push_back(bus.IRQ);
    if (e_take) begin
      m_epc  = m_pc4;
      m_pend = 1'b0;
    end else if (s && !m_pc4[31]) begin
      m_pend = 1'b1;
    end
    if (m_kind == 0) begin
      m_instr = bus.IF_Instruct; m_pc4 = bus.IF_PC4; m_valid = 1'b1;
    end else if (m_kind == 1) begin
      m_instr = NOP; m_pc4 = bus.IF_PC4; m_valid = 1'b0;
    end
  endtask

  // one clock: combinational checks before the edge, register checks after
  task automatic tick();
    #2;
    model_eval();
    check("PCWrite", bus.PCWrite, e_pcw);
    check("Stall", bus.Stall, e_stall);
    check("ID_EX_Bubble", bus.ID_EX_Bubble, e_bub);
    check("IRQ_Taken", bus.IRQ_Taken, e_take);
    @(posedge clk);
    model_commit();
    #1;
    check("ID_Instruct", bus.ID_Instruct, m_instr);
    check("ID_PC4", bus.ID_PC4, m_pc4);
    check("ID_Valid", bus.ID_Valid, m_valid);
    check("EPC", bus.EPC, m_epc);
  endtask

  initial begin
    logic got;
    compared = 0; mismatched = 0;
    bus.IF_Instruct = 32'h0; bus.IF_PC4 = 32'h0; bus.ID_EX_MemRead = 1'b0;
    bus.ID_EX_Rt = 5'd0; bus.EX_BranchTaken = 1'b0; bus.ID_Jump = 1'b0; bus.IRQ = 1'b0;
    reset = 1'b0;
    model_reset();
    #3;
    check("rst_instr", bus.ID_Instruct, NOP);
    check("rst_pcwrite", bus.PCWrite, 1'b1);
    check("rst_stall", bus.Stall, 1'b0);
    reset = 1'b1;

    // reset while ID holds a load and a load-use stall is active
    bus.IF_Instruct = 32'h8C22_0004; bus.IF_PC4 = 32'h0000_0004;
    tick();
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd2;
    #1;
    check("pre_rst_stall", bus.Stall, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_instr", bus.ID_Instruct, NOP);
    check("async_rst_pc4", bus.ID_PC4, 32'h0);
    check("async_rst_valid", bus.ID_Valid, 1'b0);
    check("async_rst_stall", bus.Stall, 1'b0);
    check("async_rst_pcwrite", bus.PCWrite, 1'b1);
    model_reset();
    reset = 1'b1;
    bus.ID_EX_MemRead = 1'b0; bus.ID_EX_Rt = 5'd0;
    bus.IF_Instruct = 32'h2001_0005; bus.IF_PC4 = 32'h0000_0008;
    tick();
    check("post_rst_instr", bus.ID_Instruct, 32'h2001_0005);
    check("post_rst_pc4", bus.ID_PC4, 32'h0000_0008);
    check("post_rst_valid", bus.ID_Valid, 1'b1);

    // load-use for one cycle, then the Rt=0 variant does not stall
    bus.IF_Instruct = 32'h0041_1820; bus.IF_PC4 = 32'h0000_000C;
    tick();
    bus.IF_Instruct = 32'h2002_0007; bus.IF_PC4 = 32'h0000_0010;
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd2;
    #1;
    check("lu_stall", bus.Stall, 1'b1);
    check("lu_pcwrite", bus.PCWrite, 1'b0);
    check("lu_bubble", bus.ID_EX_Bubble, 1'b1);
    tick();
    check("lu_hold", bus.ID_Instruct, 32'h0041_1820);
    bus.ID_EX_Rt = 5'd0;
    #1;
    check("rt0_stall", bus.Stall, 1'b0);
    tick();
    check("rt0_load", bus.ID_Instruct, 32'h2002_0007);

    // branch during a load-use stall
    bus.ID_EX_MemRead = 1'b0;
    bus.IF_Instruct = 32'h0041_1820; bus.IF_PC4 = 32'h0000_0014;
    tick();
    bus.ID_EX_MemRead = 1'b1; bus.ID_EX_Rt = 5'd2; bus.EX_BranchTaken = 1'b1;
    #1;
    check("br_stall", bus.Stall, 1'b0);
    check("br_pcwrite", bus.PCWrite, 1'b1);
    tick();
    check("br_instr", bus.ID_Instruct, NOP);
    check("br_valid", bus.ID_Valid, 1'b0);
    bus.EX_BranchTaken = 1'b0; bus.ID_EX_MemRead = 1'b0; bus.ID_EX_Rt = 5'd0;

    // jump kills the delay-slot fetch without a bubble
    bus.IF_Instruct = 32'h0800_0010; bus.IF_PC4 = 32'h0000_0018;
    tick();
    bus.IF_Instruct = 32'h2003_0001; bus.IF_PC4 = 32'h0000_001C; bus.ID_Jump = 1'b1;
    #1;
    check("jmp_bubble", bus.ID_EX_Bubble, 1'b0);
    check("jmp_pcwrite", bus.PCWrite, 1'b1);
    tick();
    check("jmp_instr", bus.ID_Instruct, NOP);
    bus.ID_Jump = 1'b0;

    // user-mode interrupt: accepted IRQ_SYNC+1 cycles after it rises
    bus.IF_Instruct = 32'h2001_0005; bus.IF_PC4 = 32'h0000_0040;
    tick();
    bus.IRQ = 1'b1;
    for (int k = 0; k <= IRQ_SYNC + 1; k++) begin
      #1;
      check("irq_latency", bus.IRQ_Taken, (k == IRQ_SYNC + 1) ? 1'b1 : 1'b0);
      tick();
      bus.IRQ = 1'b0;
    end
    check("irq_epc", bus.EPC, 32'h0000_0040);
    check("irq_flush", bus.ID_Instruct, NOP);
    #1;
    check("irq_no_repeat", bus.IRQ_Taken, 1'b0);
    tick();

    // supervisor-mode interrupt waits for user mode
    bus.IF_PC4 = 32'h8000_0040;
    tick();
    bus.IRQ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("supv_ignored", bus.IRQ_Taken, 1'b0);
      tick();
    end
    bus.IF_PC4 = 32'h0000_0040;
    tick();
    got = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      #1;
      if (bus.IRQ_Taken) got = 1'b1;
      else tick();
    end
    check("supv_then_user_taken", got, 1'b1);
    bus.IRQ = 1'b0;
    tick();
    check("supv_epc", bus.EPC, 32'h0000_0040);
    for (int k = 0; k < 8; k++) tick();

    // pending interrupt coincident with a taken branch
    bus.IRQ = 1'b1;
    tick();
    bus.IRQ = 1'b0;
    tick();
    tick();
    bus.EX_BranchTaken = 1'b1;
    #1;
    check("irq_br_blocked", bus.IRQ_Taken, 1'b0);
    tick();
    bus.EX_BranchTaken = 1'b0;
    #1;
    check("irq_br_invalid", bus.IRQ_Taken, 1'b0);
    tick();
    #1;
    check("irq_br_later", bus.IRQ_Taken, 1'b1);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bus.IF_Instruct    = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
      bus.IF_PC4         = {($urandom_range(0, 3) == 0), 31'($urandom)};
      bus.ID_EX_MemRead  = ($urandom_range(0, 1) == 1);
      bus.ID_EX_Rt       = 5'($urandom_range(0, 3));
      bus.EX_BranchTaken = ($urandom_range(0, 7) == 0);
      bus.ID_Jump        = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) bus.IRQ = ~bus.IRQ;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
